dmem_io_multi: RTL and testbench

//  Parametrised data memory with memory-mapped IO for LEGLite processors.

---
 rtl/dmem_io_multi_pkg.sv | 36 +++
 rtl/dmem_io_multi_debounce.sv | 50 +++++
 rtl/dmem_io_multi.sv | 118 +++++++++++
 tb/tb_dmem_io_multi.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_io_multi_pkg.sv
// Shared IO register offsets, display field layout and the hex-to-segment decoder
// for the LEGLite data memory with memory-mapped IO.
package dmem_io_multi_pkg;

    localparam int OFS_SWITCH = 0;
    localparam int OFS_SWCHG  = 1;
    localparam int OFS_DISP   = 2;

    localparam int         DISP_BLANK = 4;
    localparam logic [4:0] DISP_RESET = 5'b10000;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex7seg(input logic [3:0] i_hex);
        logic [6:0] w_seg;
        case (i_hex)
            4'h0:    w_seg = 7'h3F;
            4'h1:    w_seg = 7'h06;
            4'h2:    w_seg = 7'h5B;
            4'h3:    w_seg = 7'h4F;
            4'h4:    w_seg = 7'h66;
            4'h5:    w_seg = 7'h6D;
            4'h6:    w_seg = 7'h7D;
            4'h7:    w_seg = 7'h07;
            4'h8:    w_seg = 7'h7F;
            4'h9:    w_seg = 7'h6F;
            4'hA:    w_seg = 7'h77;
            4'hB:    w_seg = 7'h7C;
            4'hC:    w_seg = 7'h39;
            4'hD:    w_seg = 7'h5E;
            4'hE:    w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/dmem_io_multi_debounce.sv
// One switch channel: two-flop synchroniser followed by a debouncer that accepts
// a new level only after it has been stable for DEBOUNCE consecutive cycles.
module io_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic chg
);

    localparam int            CW     = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff = (r_sync2 != r_level);
    assign w_done = w_diff && (r_cnt == C_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end

    assign level = r_level;
    assign chg   = w_done;

endmodule

// File: rtl/dmem_io_multi.sv
// LEGLite data memory: word RAM below DEPTH plus switch, sticky change and
// 7-segment display registers mapped from IO_BASE upward.
module dmem_io_multi
    import dmem_io_multi_pkg::*;
#(
    parameter int          DEPTH    = 128,
    parameter int          NUM_SW   = 4,
    parameter int          NUM_DISP = 2,
    parameter int          DEBOUNCE = 4,
    parameter logic [15:0] IO_BASE  = 16'hFFF0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [15:0]           dmemaddr,
    input  logic [15:0]           dmemwdata,
    input  logic                  dmemwrite,
    input  logic                  dmemread,
    input  logic [NUM_SW-1:0]     io_sw,
    output logic [15:0]           dmemrdata,
    output logic [7*NUM_DISP-1:0] io_display,
    output logic                  io_irq
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    logic [15:0]       r_ram [DEPTH];
    logic [4:0]        r_disp [NUM_DISP];
    logic [NUM_SW-1:0] r_swchg;
    logic              r_irq;

    logic [NUM_SW-1:0] w_level;
    logic [NUM_SW-1:0] w_chg;
    logic [NUM_SW-1:0] w_swchg_next;
    logic              w_ram_hit;
    logic              w_io_hit;
    logic              w_clr;
    logic [15:0]       w_ofs;

    assign w_ram_hit = (dmemaddr < DEPTH_W);
    assign w_io_hit  = (dmemaddr >= IO_BASE);
    assign w_ofs     = dmemaddr - IO_BASE;
    assign w_clr     = dmemread && w_io_hit && (w_ofs == 16'(OFS_SWCHG));

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
        io_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_debounce (
            .clock  (clock),
            .reset_n(reset_n),
            .raw    (io_sw[gi]),
            .level  (w_level[gi]),
            .chg    (w_chg[gi])
        );
    end

    // Set beats clear: a change landing on the clearing read stays visible.
    assign w_swchg_next = (r_swchg & ~{NUM_SW{w_clr}}) | w_chg;

    always_ff @(posedge clock) begin
        if (dmemwrite && w_ram_hit) begin
            r_ram[dmemaddr[AW-1:0]] <= dmemwdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_DISP; k++) begin
                r_disp[k] <= DISP_RESET;
            end
        end else if (dmemwrite && w_io_hit) begin
            for (int k = 0; k < NUM_DISP; k++) begin
                if (w_ofs == 16'(OFS_DISP + k)) begin
                    r_disp[k] <= dmemwdata[4:0];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_swchg <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_swchg <= w_swchg_next;
            r_irq   <= |w_swchg_next;
        end
    end

    always_comb begin
        dmemrdata = 16'h0000;
        if (w_ram_hit) begin
            dmemrdata = r_ram[dmemaddr[AW-1:0]];
        end else if (w_io_hit) begin
            if (w_ofs == 16'(OFS_SWITCH)) begin
                dmemrdata[NUM_SW-1:0] = w_level;
            end
            if (w_ofs == 16'(OFS_SWCHG)) begin
                dmemrdata[NUM_SW-1:0] = r_swchg;
            end
            for (int k = 0; k < NUM_DISP; k++) begin
                if (w_ofs == 16'(OFS_DISP + k)) begin
                    dmemrdata[4:0] = r_disp[k];
                end
            end
        end
    end

    always_comb begin
        io_display = '0;
        for (int k = 0; k < NUM_DISP; k++) begin
            io_display[7*k +: 7] = r_disp[k][DISP_BLANK] ? 7'b0 : hex7seg(r_disp[k][3:0]);
        end
    end

    assign io_irq = r_irq;

endmodule

// File: tb/tb_dmem_io_multi.sv
// Scoreboard bench for dmem_io_multi: directed scenarios plus a random phase
// checked against a window-based behavioural model of the memory and IO.
module tb_dmem_io_multi;

    localparam int          DEPTH    = 128;
    localparam int          NUM_SW   = 4;
    localparam int          NUM_DISP = 2;
    localparam int          DEBOUNCE = 4;
    localparam logic [15:0] IO_BASE  = 16'hFFF0;

    localparam int K_RD   = 0;
    localparam int K_DISP = 1;
    localparam int K_IRQ  = 2;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [15:0]           dmemaddr = 16'h0;
    logic [15:0]           dmemwdata = 16'h0;
    logic                  dmemwrite = 1'b0;
    logic                  dmemread = 1'b0;
    logic [NUM_SW-1:0]     io_sw = '0;
    logic [15:0]           dmemrdata;
    logic [7*NUM_DISP-1:0] io_display;
    logic                  io_irq;

    always #5 clock = ~clock;

    dmem_io_multi #(
        .DEPTH   (DEPTH),
        .NUM_SW  (NUM_SW),
        .NUM_DISP(NUM_DISP),
        .DEBOUNCE(DEBOUNCE),
        .IO_BASE (IO_BASE)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .dmemaddr  (dmemaddr),
        .dmemwdata (dmemwdata),
        .dmemwrite (dmemwrite),
        .dmemread  (dmemread),
        .io_sw     (io_sw),
        .dmemrdata (dmemrdata),
        .io_display(io_display),
        .io_irq    (io_irq)
    );

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Behavioural model: switch levels from a sliding window of synchronised samples.
    logic [NUM_SW-1:0] m_level;
    logic [NUM_SW-1:0] m_swchg;
    logic              m_irq;
    logic [4:0]        m_disp [NUM_DISP];
    logic [15:0]       m_ram [int];
    logic [NUM_SW-1:0] m_raw_q[$];
    logic [NUM_SW-1:0] m_win_q[$];

    task automatic model_reset();
        m_level = '0;
        m_swchg = '0;
        m_irq   = 1'b0;
        for (int k = 0; k < NUM_DISP; k++) m_disp[k] = 5'b10000;
        m_raw_q = {};
        m_raw_q.push_back('0);
        m_raw_q.push_back('0);
        m_win_q = {};
    endtask

    task automatic model_step();
        logic [NUM_SW-1:0] s;
        logic [NUM_SW-1:0] chg;
        bit                all_diff;
        s = m_raw_q.pop_front();
        m_raw_q.push_back(io_sw);
        m_win_q.push_back(s);
        if (m_win_q.size() > DEBOUNCE) void'(m_win_q.pop_front());
        chg = '0;
        if (m_win_q.size() == DEBOUNCE) begin
            for (int i = 0; i < NUM_SW; i++) begin
                all_diff = 1'b1;
                foreach (m_win_q[j]) if (m_win_q[j][i] == m_level[i]) all_diff = 1'b0;
                chg[i] = all_diff;
            end
        end
        m_level = m_level ^ chg;
        if (dmemread && dmemaddr == IO_BASE + 16'd1) m_swchg = '0;
        m_swchg = m_swchg | chg;
        m_irq   = |m_swchg;
        if (dmemwrite) begin
            if (dmemaddr < DEPTH) m_ram[int'(dmemaddr)] = dmemwdata;
            for (int k = 0; k < NUM_DISP; k++)
                if (dmemaddr == IO_BASE + 16'(2 + k)) m_disp[k] = dmemwdata[4:0];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    function automatic bit model_rd(input logic [15:0] a, output logic [15:0] v);
        v = 16'h0;
        if (a < DEPTH) begin
            if (!m_ram.exists(int'(a))) return 1'b0;
            v = m_ram[int'(a)];
        end else if (a == IO_BASE) begin
            v[NUM_SW-1:0] = m_level;
        end else if (a == IO_BASE + 16'd1) begin
            v[NUM_SW-1:0] = m_swchg;
        end else begin
            for (int k = 0; k < NUM_DISP; k++)
                if (a == IO_BASE + 16'(2 + k)) v = {11'b0, m_disp[k]};
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] model_disp();
        logic [15:0] v;
        v = 16'h0;
        for (int k = 0; k < NUM_DISP; k++)
            if (!m_disp[k][4]) v[7*k +: 7] = SEG[m_disp[k][3:0]];
        return v;
    endfunction

    function automatic void push(input int kind, input logic [15:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        exp_q.push_back(e);
    endfunction

    function automatic void push_status(input string nm);
        push(K_DISP, model_disp(), {nm, "_disp"});
        push(K_IRQ, {15'b0, m_irq}, {nm, "_irq"});
    endfunction

    function automatic void push_model_rd(input logic [15:0] a, input string nm);
        logic [15:0] v;
        if (model_rd(a, v)) push(K_RD, v, nm);
    endfunction

    // Monitor: compares everything queued for this cycle at the falling edge.
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_RD:    act = dmemrdata;
                    K_DISP:  act = 16'(io_display);
                    default: act = {15'b0, io_irq};
                endcase
                n_vec++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: actual=%h required=%h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
        dmemwrite = 1'b0;
        dmemread  = 1'b0;
    endtask

    task automatic set_rd(input logic [15:0] a);
        dmemread = 1'b1;
        dmemaddr = a;
    endtask

    task automatic set_wr(input logic [15:0] a, input logic [15:0] d);
        dmemwrite = 1'b1;
        dmemaddr  = a;
        dmemwdata = d;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] v, input string nm);
        next_cycle();
        set_rd(a);
        push(K_RD, v, nm);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        next_cycle();
        set_wr(a, d);
    endtask

    initial begin
        logic [15:0] a;
        int          sel;

        // Reset state
        next_cycle();
        push(K_DISP, 16'h0, "rst_disp");
        push(K_IRQ, 16'h0, "rst_irq");
        rd(IO_BASE, 16'h0, "rst_switch");
        rd(IO_BASE + 16'd1, 16'h0, "rst_swchg");
        next_cycle();
        reset_n = 1'b1;
        repeat (8) begin
            next_cycle();
            set_rd(IO_BASE);
            push(K_RD, 16'h0, "idle_switch");
            push(K_IRQ, 16'h0, "idle_irq");
        end
        rd(IO_BASE + 16'd1, 16'h0, "idle_swchg");

        // RAM and unmapped space
        wr(16'd5, 16'hA5A5);
        rd(16'd5, 16'hA5A5, "ram_rd5");
        wr(16'(DEPTH), 16'h1234);
        rd(16'(DEPTH), 16'h0, "unmapped_depth");
        rd(IO_BASE - 16'd1, 16'h0, "unmapped_below_io");
        rd(16'd5, 16'hA5A5, "ram_rd5_again");

        // Displays
        wr(IO_BASE + 16'd2, 16'h0003);
        rd(IO_BASE + 16'd2, 16'h0003, "disp0_rd");
        push(K_DISP, 16'h004F, "disp0_three");
        wr(IO_BASE + 16'd2, 16'h0010);
        rd(IO_BASE + 16'd2, 16'h0010, "disp0_blank_rd");
        push(K_DISP, 16'h0000, "disp0_blank");
        wr(IO_BASE, 16'hFFFF);
        rd(IO_BASE, 16'h0000, "switch_ro");
        wr(IO_BASE + 16'd3, 16'h000A);
        rd(IO_BASE + 16'd3, 16'h000A, "disp1_rd");
        push(K_DISP, 16'h3B80, "disp1_a");
        rd(IO_BASE + 16'(2 + NUM_DISP), 16'h0, "unmapped_io");
        wr(IO_BASE + 16'd3, 16'h0010);

        // Debounce latency on io_sw[1]
        next_cycle();
        io_sw[1] = 1'b1;
        for (int i = 1; i <= 2 + DEBOUNCE; i++) begin
            rd(IO_BASE, (i == 2 + DEBOUNCE) ? 16'h0002 : 16'h0000, "deb_latency");
            push(K_IRQ, (i == 2 + DEBOUNCE) ? 16'h1 : 16'h0, "deb_irq");
        end

        // Short glitch on io_sw[0] is rejected
        for (int i = 0; i < DEBOUNCE + 8; i++) begin
            next_cycle();
            io_sw[0] = (i < DEBOUNCE - 1);
            set_rd(IO_BASE);
            push(K_RD, 16'h0002, "glitch_switch");
        end

        // Sticky change register and irq
        rd(IO_BASE + 16'd1, 16'h0002, "swchg_set");
        push(K_IRQ, 16'h1, "irq_set");
        rd(IO_BASE + 16'd1, 16'h0000, "swchg_cleared");
        push(K_IRQ, 16'h0, "irq_cleared");

        // Change coincident with the clearing read
        next_cycle();
        io_sw[2] = 1'b1;
        for (int i = 1; i <= 4; i++) rd(IO_BASE, 16'h0002, "coinc_wait");
        rd(IO_BASE + 16'd1, 16'h0000, "coinc_preclear");
        rd(IO_BASE + 16'd1, 16'h0004, "coinc_set_wins");
        push(K_IRQ, 16'h1, "coinc_irq");
        rd(IO_BASE + 16'd1, 16'h0000, "coinc_cleared");
        push(K_IRQ, 16'h0, "coinc_irq_clr");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            next_cycle();
            if ($urandom_range(0, 11) == 0) io_sw[$urandom_range(0, NUM_SW - 1)] ^= 1'b1;
            sel = int'($urandom_range(0, 4));
            if (sel <= 1) a = 16'($urandom_range(0, 15));
            else if (sel == 2) a = 16'(DEPTH) + 16'($urandom_range(0, 15));
            else a = IO_BASE + 16'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: ;
                1: set_wr(a, 16'($urandom()));
                default: begin
                    set_rd(a);
                    push_model_rd(a, "rand_rd");
                end
            endcase
            push_status("rand");
        end

        // Reset in the middle of a debounce
        next_cycle();
        io_sw = 4'b0010;
        repeat (2 * DEBOUNCE + 6) next_cycle();
        wr(IO_BASE + 16'd2, 16'h0007);
        next_cycle();
        io_sw = 4'b1010;
        set_rd(IO_BASE);
        push_model_rd(IO_BASE, "pre_rst_switch");
        push_status("pre_rst");
        repeat (2) next_cycle();
        next_cycle();
        #2;
        reset_n = 1'b0;
        set_rd(IO_BASE);
        push(K_RD, 16'h0, "midrst_switch");
        push(K_DISP, 16'h0, "midrst_disp");
        push(K_IRQ, 16'h0, "midrst_irq");
        rd(IO_BASE + 16'd2, 16'h0010, "midrst_disp_reg");
        next_cycle();
        reset_n = 1'b1;
        for (int i = 1; i <= 2 + DEBOUNCE; i++)
            rd(IO_BASE, (i == 2 + DEBOUNCE) ? 16'h000A : 16'h0000, "rerun_switch");
        rd(IO_BASE + 16'd1, 16'h000A, "rerun_swchg");
        push(K_IRQ, 16'h1, "rerun_irq");

        repeat (3) next_cycle();
        @(posedge clock);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
